// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative RV32M multiplier: state encoding,
// funct3 -> {ext_A, ext_B, upper} decode and default widths.
package mul_pkg;

  localparam int unsigned MulXlen = 32;
  localparam int unsigned MulDw   = 8;

  typedef logic [1:0] mul_state_t;

  localparam mul_state_t StIdle = 2'd0;
  localparam mul_state_t StCalc = 2'd1;
  localparam mul_state_t StSign = 2'd2;

  typedef struct packed {
    logic ext_a;
    logic ext_b;
    logic upper;
  } mul_ctrl_t;

  localparam logic [2:0] Funct3Mul    = 3'b000;
  localparam logic [2:0] Funct3Mulh   = 3'b001;
  localparam logic [2:0] Funct3Mulhsu = 3'b010;
  localparam logic [2:0] Funct3Mulhu  = 3'b011;

  localparam mul_ctrl_t CtrlMul    = '{ext_a: 1'b0, ext_b: 1'b0, upper: 1'b0};
  localparam mul_ctrl_t CtrlMulh   = '{ext_a: 1'b1, ext_b: 1'b1, upper: 1'b1};
  localparam mul_ctrl_t CtrlMulhsu = '{ext_a: 1'b1, ext_b: 1'b0, upper: 1'b1};
  localparam mul_ctrl_t CtrlMulhu  = '{ext_a: 1'b0, ext_b: 1'b0, upper: 1'b1};

  function automatic mul_ctrl_t mul_decode(input logic [2:0] funct3);
    mul_ctrl_t ctrl;
    case (funct3)
      Funct3Mulh:   ctrl = CtrlMulh;
      Funct3Mulhsu: ctrl = CtrlMulhsu;
      Funct3Mulhu:  ctrl = CtrlMulhu;
      default:      ctrl = CtrlMul;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/digit_mac.sv
// Combinational XLEN x DW partial product, shifted into place by digit index and
// added to the 2*XLEN accumulator.
module digit_mac
  import mul_pkg::*;
#(
  parameter int unsigned XLEN = MulXlen,
  parameter int unsigned DW   = MulDw,
  parameter int unsigned IdxW = 3
) (
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [DW-1:0]     digit_i,
  input  logic [IdxW-1:0]   idx_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN+DW-1:0] pp;
  logic [2*XLEN-1:0]  pp_ext;

  always_comb begin
    pp     = {{DW{1'b0}}, a_i} * {{XLEN{1'b0}}, digit_i};
    pp_ext = {{(XLEN-DW){1'b0}}, pp};
    acc_o  = acc_i + (pp_ext << (DW * idx_i));
  end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative XLEN x XLEN multiplier retiring DW bits of B per cycle (MUL/MULH/MULHSU/MULHU).
// Optional SEQ_MUL_EARLY_EXIT_EN: leave CALC once the remaining |B| digits are all zero.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int unsigned XLEN = MulXlen,
  parameter int unsigned DW   = MulDw
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] op_A_i,
  input  logic [XLEN-1:0] op_B_i,
  input  logic            ext_A_i,
  input  logic            ext_B_i,
  input  logic            upper_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned N    = XLEN / DW;
  localparam int unsigned CntW = $clog2(N + 1);

  mul_state_t        state_q, state_d;
  logic [XLEN-1:0]   a_mag_q, a_mag_d;
  logic [XLEN-1:0]   b_mag_q, b_mag_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              upper_q, upper_d;
  logic              done_q, done_d;

  logic              sign_a, sign_b;
  logic [XLEN-1:0]   b_shift;
  logic [CntW-1:0]   digit_idx;
  logic [2*XLEN-1:0] acc_mac;
  logic [2*XLEN-1:0] prod;
  logic              calc_last;

  assign sign_a    = ext_A_i & op_A_i[XLEN-1];
  assign sign_b    = ext_B_i & op_B_i[XLEN-1];
  assign b_shift   = b_mag_q >> DW;
  assign digit_idx = CntW'(N) - cnt_q;
  // Negating a zero accumulator gives zero, so neg needs no zero-operand special case.
  assign prod      = neg_q ? -acc_q : acc_q;

`ifdef SEQ_MUL_EARLY_EXIT_EN
  assign calc_last = (cnt_q == CntW'(1)) || (b_shift == '0);
`else
  assign calc_last = (cnt_q == CntW'(1));
`endif

  digit_mac #(
    .XLEN (XLEN),
    .DW   (DW),
    .IdxW (CntW)
  ) u_digit_mac (
    .acc_i   (acc_q),
    .a_i     (a_mag_q),
    .digit_i (b_mag_q[DW-1:0]),
    .idx_i   (digit_idx),
    .acc_o   (acc_mac)
  );

  always_comb begin
    state_d  = state_q;
    a_mag_d  = a_mag_q;
    b_mag_d  = b_mag_q;
    result_d = result_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    upper_d  = upper_q;
    done_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          a_mag_d = sign_a ? -op_A_i : op_A_i;
          b_mag_d = sign_b ? -op_B_i : op_B_i;
          neg_d   = sign_a ^ sign_b;
          upper_d = upper_i;
          acc_d   = '0;
          cnt_d   = CntW'(N);
          state_d = StCalc;
        end
      end
      StCalc: begin
        acc_d   = acc_mac;
        b_mag_d = b_shift;
        cnt_d   = cnt_q - 1'b1;
        if (calc_last) begin
          state_d = StSign;
        end
      end
      StSign: begin
        result_d = upper_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      result_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      upper_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_mag_q  <= a_mag_d;
      b_mag_q  <= b_mag_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      upper_q  <= upper_d;
      done_q   <= done_d;
    end
  end

  assign busy_o   = (state_q != StIdle);
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule
